output_scheduler: RTL

Round-robin scheduler that shares the single serializer in output_stage among 8 upstream channel requesters.
- Accepts one 128-bit Gray-coded frame plus a bit length per channel.
- Grants one channel at a time and issues a single-cycle one-hot vld_ch with registered data_gray/data_count.
- Tracks the transfer through crc_valid and inserts a configurable idle gap before the next grant.
- Sits directly upstream of output_stage, in the clk_out16x domain.

---
 rtl/output_sched_pkg.sv | 33 +++
 rtl/output_sched_if.sv | 30 +++
 rtl/output_scheduler_rr_arbiter.sv | 28 ++
 rtl/output_scheduler.sv | 123 ++++++++++++
 4 files changed

// File: rtl/output_sched_pkg.sv
// Shared types and helpers for the output_stage round-robin scheduler.
// Sizes are fixed by the serializer datapath in output_stage.
package output_sched_pkg;

   localparam int NCH     = 8;
   localparam int DW      = 128;
   localparam int MAX_LEN = 128;
   localparam int IW      = $clog2(NCH);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_START,
      BUSY,
      GAP
   } state_e;

   function automatic logic [NCH-1:0] onehot(input logic [IW-1:0] idx);
      logic [NCH-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [7:0] clamp_len(input logic [7:0] len);
      return (len > 8'(MAX_LEN)) ? 8'(MAX_LEN) : len;
   endfunction

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
      return (int'(idx) == NCH - 1) ? '0 : IW'(int'(idx) + 1);
   endfunction

endpackage

// File: rtl/output_sched_if.sv
// Requester and serializer side signals of the output scheduler.
// master = scheduler, slave = requesters plus output_stage.
interface output_sched_if import output_sched_pkg::*; ();

   logic [NCH-1:0]    ch_enable;
   logic [NCH-1:0]    req;
   logic [NCH*DW-1:0] req_data;
   logic [NCH*8-1:0]  req_len;
   logic [NCH-1:0]    req_ack;
   logic [DW-1:0]     data_gray;
   logic [15:0]       data_count;
   logic [NCH-1:0]    vld_ch;
   logic              crc_valid;
   logic              sched_busy;
   logic              err_len;
   logic              err_nostart;

   modport master (
      input  ch_enable, req, req_data, req_len, crc_valid,
      output req_ack, data_gray, data_count, vld_ch,
      output sched_busy, err_len, err_nostart
   );

   modport slave (
      output ch_enable, req, req_data, req_len, crc_valid,
      input  req_ack, data_gray, data_count, vld_ch,
      input  sched_busy, err_len, err_nostart
   );

endinterface

// File: rtl/output_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first eligible channel at or after ptr.
// The pointer register lives in the parent.
module rr_arbiter import output_sched_pkg::*; (
   input  logic [NCH-1:0] eligible,
   input  logic [IW-1:0]  ptr,
   output logic [NCH-1:0] grant,
   output logic [IW-1:0]  grant_idx,
   output logic           found
);

   logic [IW-1:0] idx;

   // Walk from the lowest priority down so the last hit is the winner.
   always_comb begin
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         idx = IW'((int'(ptr) + k) % NCH);
         if (eligible[idx]) begin
            grant_idx = idx;
            found     = 1'b1;
         end
      end
      grant = onehot(grant_idx) & {NCH{found}};
   end

endmodule

// File: rtl/output_scheduler.sv
// Round-robin scheduler sharing the output_stage serializer among NCH
// requesters, with issue tracking through crc_valid and an idle gap.
module output_scheduler import output_sched_pkg::*; #(
   parameter int GAP_CYC = 1
) (
   input logic            clk_out16x,
   input logic            rst_n,
   output_sched_if.master bus
);

   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   state_e         state_q, state_d, after_busy;
   logic [IW-1:0]  ptr_q;
   logic [GW-1:0]  gap_q;
   logic           gap_done;

   logic [NCH-1:0] elig, win_oh;
   logic [IW-1:0]  win_idx;
   logic           win_any;
   logic [7:0]     win_len;
   logic           len_zero, len_over;

   logic [NCH-1:0] vld_d, ack_d;
   logic           err_len_d, err_nostart_d, load;

   logic [NCH-1:0] vld_q, ack_q;
   logic           err_len_q, err_nostart_q;
   logic [DW-1:0]  gray_q;
   logic [15:0]    count_q;

   // A channel acked this cycle still shows req until its owner reacts.
   assign elig = bus.req & bus.ch_enable & ~ack_q;

   rr_arbiter u_arb (
      .eligible  (elig),
      .ptr       (ptr_q),
      .grant     (win_oh),
      .grant_idx (win_idx),
      .found     (win_any)
   );

   assign win_len  = bus.req_len[int'(win_idx)*8 +: 8];
   assign len_zero = (win_len == 8'd0);
   assign len_over = (win_len > 8'(MAX_LEN));

   assign after_busy = (GAP_CYC == 0) ? IDLE : GAP;
   assign gap_done   = (GAP_CYC == 0) ||
                       (int'(gap_q) == GAP_CYC - 1);

   always_ff @(posedge clk_out16x or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:       if (win_any && !len_zero) state_d = ISSUE;
         ISSUE:      state_d = WAIT_START;
         WAIT_START: state_d = bus.crc_valid ? BUSY : after_busy;
         BUSY:       if (!bus.crc_valid) state_d = after_busy;
         GAP:        if (gap_done) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      vld_d         = '0;
      ack_d         = '0;
      err_len_d     = 1'b0;
      err_nostart_d = 1'b0;
      load          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_any) begin
               ack_d     = win_oh;
               err_len_d = len_zero | len_over;
               if (!len_zero) begin
                  vld_d = win_oh;
                  load  = 1'b1;
               end
            end
         end
         WAIT_START: err_nostart_d = !bus.crc_valid;
         default: ;
      endcase
   end

   always_ff @(posedge clk_out16x or negedge rst_n) begin
      if (!rst_n) begin
         vld_q         <= '0;
         ack_q         <= '0;
         err_len_q     <= 1'b0;
         err_nostart_q <= 1'b0;
         gray_q        <= '0;
         count_q       <= '0;
         ptr_q         <= '0;
         gap_q         <= '0;
      end else begin
         vld_q         <= vld_d;
         ack_q         <= ack_d;
         err_len_q     <= err_len_d;
         err_nostart_q <= err_nostart_d;
         if (load) begin
            gray_q  <= bus.req_data[int'(win_idx)*DW +: DW];
            count_q <= {8'd0, clamp_len(win_len)};
         end
         if (state_q == IDLE && win_any)
            ptr_q <= wrap_inc(win_idx);
         gap_q <= (state_q == GAP) ? gap_q + 1'b1 : '0;
      end
   end

   assign bus.vld_ch      = vld_q;
   assign bus.req_ack     = ack_q;
   assign bus.err_len     = err_len_q;
   assign bus.err_nostart = err_nostart_q;
   assign bus.data_gray   = gray_q;
   assign bus.data_count  = count_q;
   assign bus.sched_busy  = (state_q != IDLE);

endmodule
